apu_write_arbiter: RTL

APU_WRITE_ARBITER -- requirements
Module: apu_write_arbiter

---
 rtl/apu_pkg.sv | 21 ++
 rtl/apu_regfile.sv | 87 ++++++++
 rtl/apu_write_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared definitions for the APU write path.
//   - arb_state_e : arbiter state, also the encoding of the 'owner' output
//                   (0 none, 1 host, 2 sequencer)
//   - REG_P*_LO/HI: period low/high register indices for pulse 1 and pulse 2
//   - BURST_MAX_DEFAULT: default cap on writes per locked burst
package apu_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StHostBurst = 2'd1,
    StSeqBurst  = 2'd2
  } arb_state_e;

  localparam logic [2:0] REG_P1_LO = 3'd2;
  localparam logic [2:0] REG_P1_HI = 3'd3;
  localparam logic [2:0] REG_P2_LO = 3'd6;
  localparam logic [2:0] REG_P2_HI = 3'd7;

  localparam int unsigned BURST_MAX_DEFAULT = 4;

endpackage

// File: rtl/apu_regfile.sv
// APU register file: eight committed 8-bit registers, two period-low shadows
// and the pulse restart strobes.
//   clk, reset          : clock, synchronous active-high reset
//   wr_en/addr/data     : one granted write per cycle
//   apu_reg_0..7        : committed registers
//   p1_restart/p2_restart : one-cycle strobe after a reg 3 / reg 7 write
module apu_regfile
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] apu_reg_0,
  output logic [7:0] apu_reg_1,
  output logic [7:0] apu_reg_2,
  output logic [7:0] apu_reg_3,
  output logic [7:0] apu_reg_4,
  output logic [7:0] apu_reg_5,
  output logic [7:0] apu_reg_6,
  output logic [7:0] apu_reg_7,
  output logic       p1_restart,
  output logic       p2_restart
);

  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic [7:0] shadow_lo1_q, shadow_lo1_d;
  logic [7:0] shadow_lo2_q, shadow_lo2_d;
  logic       p1_restart_q, p1_restart_d;
  logic       p2_restart_q, p2_restart_d;

  always_comb begin
    regs_d       = regs_q;
    shadow_lo1_d = shadow_lo1_q;
    shadow_lo2_d = shadow_lo2_q;
    p1_restart_d = 1'b0;
    p2_restart_d = 1'b0;
    if (wr_en) begin
      case (wr_addr)
        // Period-low writes are staged so the 11-bit period changes atomically.
        REG_P1_LO: shadow_lo1_d = wr_data;
        REG_P2_LO: shadow_lo2_d = wr_data;
        REG_P1_HI: begin
          regs_d[REG_P1_HI] = wr_data;
          regs_d[REG_P1_LO] = shadow_lo1_q;
          p1_restart_d      = 1'b1;
        end
        REG_P2_HI: begin
          regs_d[REG_P2_HI] = wr_data;
          regs_d[REG_P2_LO] = shadow_lo2_q;
          p2_restart_d      = 1'b1;
        end
        default: regs_d[wr_addr] = wr_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
      shadow_lo1_q <= 8'h00;
      shadow_lo2_q <= 8'h00;
      p1_restart_q <= 1'b0;
      p2_restart_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      shadow_lo1_q <= shadow_lo1_d;
      shadow_lo2_q <= shadow_lo2_d;
      p1_restart_q <= p1_restart_d;
      p2_restart_q <= p2_restart_d;
    end
  end

  assign apu_reg_0  = regs_q[0];
  assign apu_reg_1  = regs_q[1];
  assign apu_reg_2  = regs_q[2];
  assign apu_reg_3  = regs_q[3];
  assign apu_reg_4  = regs_q[4];
  assign apu_reg_5  = regs_q[5];
  assign apu_reg_6  = regs_q[6];
  assign apu_reg_7  = regs_q[7];
  assign p1_restart = p1_restart_q;
  assign p2_restart = p2_restart_q;

endmodule

// File: rtl/apu_write_arbiter.sv
// Arbitrates APU register writes between the serial host decoder and the
// sequencer, with optional locked bursts capped at BURST_MAX writes.
//   clk, reset                         : clock, synchronous active-high reset
//   host_valid/lock/addr/data, host_ready : host request set and grant
//   seq_valid/lock/addr/data,  seq_ready  : sequencer request set and grant
//   apu_reg_0..7, p1/p2_restart        : committed registers and restart strobes
//   owner                              : 0 none, 1 host, 2 sequencer
module apu_write_arbiter
  import apu_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_valid,
  input  logic       host_lock,
  input  logic [2:0] host_addr,
  input  logic [7:0] host_data,
  output logic       host_ready,
  input  logic       seq_valid,
  input  logic       seq_lock,
  input  logic [2:0] seq_addr,
  input  logic [7:0] seq_data,
  output logic       seq_ready,
  output logic [7:0] apu_reg_0,
  output logic [7:0] apu_reg_1,
  output logic [7:0] apu_reg_2,
  output logic [7:0] apu_reg_3,
  output logic [7:0] apu_reg_4,
  output logic [7:0] apu_reg_5,
  output logic [7:0] apu_reg_6,
  output logic [7:0] apu_reg_7,
  output logic       p1_restart,
  output logic       p2_restart,
  output logic [1:0] owner
);

  localparam int unsigned CntW = $clog2(BURST_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          rr_host_last_q, rr_host_last_d;
  logic          host_acc, seq_acc;
  logic          burst_full;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;

  // True when the write accepted this cycle would be the last one allowed.
  assign burst_full = (cnt_q + CntW'(1)) >= CntW'(BURST_MAX);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_host_last_d = rr_host_last_q;
    host_ready     = 1'b0;
    seq_ready      = 1'b0;

    // Grants depend only on state, valids and the round-robin flop.
    unique case (state_q)
      StIdle: begin
        if (host_valid && (!seq_valid || !rr_host_last_q)) host_ready = 1'b1;
        else if (seq_valid)                                seq_ready  = 1'b1;
      end
      StHostBurst: host_ready = 1'b1;
      StSeqBurst:  seq_ready  = 1'b1;
      default: ;
    endcase
    if (reset) begin
      host_ready = 1'b0;
      seq_ready  = 1'b0;
    end

    host_acc = host_valid && host_ready;
    seq_acc  = seq_valid && seq_ready;

    // Every accept updates the pointer, so a forced release favours the other side.
    if (host_acc) rr_host_last_d = 1'b1;
    if (seq_acc)  rr_host_last_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (BURST_MAX > 1) begin
          if (host_acc && host_lock) begin
            state_d = StHostBurst;
            cnt_d   = CntW'(1);
          end else if (seq_acc && seq_lock) begin
            state_d = StSeqBurst;
            cnt_d   = CntW'(1);
          end
        end
      end
      StHostBurst: begin
        if (!host_lock || (host_acc && burst_full)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (host_acc) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSeqBurst: begin
        if (!seq_lock || (seq_acc && burst_full)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (seq_acc) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rr_host_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rr_host_last_q <= rr_host_last_d;
    end
  end

  assign owner   = state_q;
  assign wr_en   = host_acc || seq_acc;
  assign wr_addr = host_acc ? host_addr : seq_addr;
  assign wr_data = host_acc ? host_data : seq_data;

  apu_regfile u_regfile (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .apu_reg_0  (apu_reg_0),
    .apu_reg_1  (apu_reg_1),
    .apu_reg_2  (apu_reg_2),
    .apu_reg_3  (apu_reg_3),
    .apu_reg_4  (apu_reg_4),
    .apu_reg_5  (apu_reg_5),
    .apu_reg_6  (apu_reg_6),
    .apu_reg_7  (apu_reg_7),
    .p1_restart (p1_restart),
    .p2_restart (p2_restart)
  );

endmodule
